// File: rtl/sw_activity_counter.sv
// Switching-activity monitor: counts bit toggles between consecutive valid samples over a window.
// Optional peak tracking is enabled by defining ACT_PEAK_EN (adds the res_peak port).
module sw_activity_counter #(
  parameter int WIDTH  = 4,
  parameter int WINDOW = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] obs,
  input  logic             obs_vld,
  output logic             busy,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [CNT_W-1:0] res_count,
  output logic             res_sat
`ifdef ACT_PEAK_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] res_peak
`endif
);

  localparam int DW  = $clog2(WIDTH + 1);
  localparam int DCW = $clog2(WINDOW + 1);
  localparam logic [DCW-1:0] LAST_DELTA = DCW'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COUNT   = 2'd2,
    REPORT  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] prev;
  logic [CNT_W-1:0] acc;
  logic [DCW-1:0]   deltas;
  logic             sat;
  logic [WIDTH-1:0] toggles;
  logic [DW-1:0]    d;
  logic [CNT_W:0]   sum;
  logic             ovf;
  logic [CNT_W-1:0] acc_nx;
  logic             last_delta;

  // Toggle count between the incoming sample and the previous valid one.
  always_comb begin
    toggles = obs ^ prev;
    d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      d = d + DW'(toggles[i]);
    end
  end

  // Saturating accumulate: the carry out of the widened add means the max was exceeded.
  always_comb begin
    sum        = {1'b0, acc} + (CNT_W + 1)'(d);
    ovf        = sum[CNT_W];
    acc_nx     = ovf ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    last_delta = (deltas == LAST_DELTA);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CAPTURE;
      CAPTURE: if (obs_vld) state_nx = COUNT;
      COUNT:   if (obs_vld && last_delta) state_nx = REPORT;
      REPORT:  if (res_rdy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // busy/res_vld are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      res_vld <= 1'b0;
    end else begin
      state   <= state_nx;
      busy    <= (state_nx == CAPTURE) || (state_nx == COUNT);
      res_vld <= (state_nx == REPORT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev   <= '0;
      acc    <= '0;
      deltas <= '0;
      sat    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= '0;
            deltas <= '0;
            sat    <= 1'b0;
          end
        end
        CAPTURE: begin
          if (obs_vld) prev <= obs;
        end
        COUNT: begin
          if (obs_vld) begin
            acc    <= acc_nx;
            sat    <= sat | ovf;
            prev   <= obs;
            deltas <= deltas + DCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign res_count = acc;
  assign res_sat   = sat;

`ifdef ACT_PEAK_EN
  logic [DW-1:0] peak;

  always_ff @(posedge clk) begin
    if (rst) begin
      peak <= '0;
    end else if (state == IDLE && start) begin
      peak <= '0;
    end else if (state == COUNT && obs_vld && d > peak) begin
      peak <= d;
    end
  end

  assign res_peak = peak;
`endif

endmodule

// File: tb/tb_sw_activity_counter.sv
// Bench for sw_activity_counter: two instances (WINDOW=4/CNT_W=16 and WINDOW=8/CNT_W=4) share stimulus
// and are checked every cycle against a behavioural model, plus hand-computed literal results.
module tb_sw_activity_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] obs = 4'h0;
  logic       obs_vld = 1'b0;
  logic       res_rdy = 1'b0;

  logic        busy_a, vld_a, sat_a;
  logic [15:0] cnt_a;
  logic        busy_b, vld_b, sat_b;
  logic [3:0]  cnt_b;
  logic [2:0]  peak_a, peak_b;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  sw_activity_counter #(.WIDTH(4), .WINDOW(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start), .obs(obs), .obs_vld(obs_vld),
    .busy(busy_a), .res_vld(vld_a), .res_rdy(res_rdy),
    .res_count(cnt_a), .res_sat(sat_a)
`ifdef ACT_PEAK_EN
    , .res_peak(peak_a)
`endif
  );

  sw_activity_counter #(.WIDTH(4), .WINDOW(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .obs(obs), .obs_vld(obs_vld),
    .busy(busy_b), .res_vld(vld_b), .res_rdy(res_rdy),
    .res_count(cnt_b), .res_sat(sat_b)
`ifdef ACT_PEAK_EN
    , .res_peak(peak_b)
`endif
  );

`ifndef ACT_PEAK_EN
  assign peak_a = 3'd0;
  assign peak_b = 3'd0;
`endif

  // Behavioural model: phase 0 idle, 1 awaiting first sample, 2 counting, 3 holding result.
  int win[2]  = '{4, 8};
  int cmax[2] = '{65535, 15};
  int m_phase[2], m_prev[2], m_acc[2], m_n[2], m_sat[2], m_peak[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_phase[i] = 0; m_prev[i] = 0; m_acc[i] = 0;
        m_n[i] = 0; m_sat[i] = 0; m_peak[i] = 0;
      end else if (m_phase[i] == 0) begin
        if (start) begin
          m_phase[i] = 1; m_acc[i] = 0; m_n[i] = 0; m_sat[i] = 0; m_peak[i] = 0;
        end
      end else if (m_phase[i] == 1) begin
        if (obs_vld) begin
          m_prev[i] = int'(obs);
          m_phase[i] = 2;
        end
      end else if (m_phase[i] == 2) begin
        if (obs_vld) begin
          int t;
          t = $countones(int'(obs) ^ m_prev[i]);
          if (m_acc[i] + t > cmax[i]) begin
            m_acc[i] = cmax[i];
            m_sat[i] = 1;
          end else begin
            m_acc[i] = m_acc[i] + t;
          end
          if (t > m_peak[i]) m_peak[i] = t;
          m_prev[i] = int'(obs);
          m_n[i] = m_n[i] + 1;
          if (m_n[i] == win[i]) m_phase[i] = 3;
        end
      end else begin
        if (res_rdy) m_phase[i] = 0;
      end
    end
  end

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model; result fields only matter while res_vld is high.
  always @(negedge clk) begin
    if (chk_on) begin
      check_output("busy_a", int'(busy_a), int'(m_phase[0] == 1 || m_phase[0] == 2));
      check_output("vld_a", int'(vld_a), int'(m_phase[0] == 3));
      check_output("busy_b", int'(busy_b), int'(m_phase[1] == 1 || m_phase[1] == 2));
      check_output("vld_b", int'(vld_b), int'(m_phase[1] == 3));
      if (m_phase[0] == 3) begin
        check_output("count_a", int'(cnt_a), m_acc[0]);
        check_output("sat_a", int'(sat_a), m_sat[0]);
`ifdef ACT_PEAK_EN
        check_output("peak_a", int'(peak_a), m_peak[0]);
`endif
      end
      if (m_phase[1] == 3) begin
        check_output("count_b", int'(cnt_b), m_acc[1]);
        check_output("sat_b", int'(sat_b), m_sat[1]);
`ifdef ACT_PEAK_EN
        check_output("peak_b", int'(peak_b), m_peak[1]);
`endif
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; obs_vld = 1'b0; res_rdy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_start();
    @(negedge clk);
    start = 1'b1; obs_vld = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [3:0] sample, input logic vld);
    @(negedge clk);
    start = 1'b0; obs = sample; obs_vld = vld;
  endtask

  // Waits for res_vld of the chosen instance; the return is the number of negedges waited.
  task automatic wait_result(input int inst, input int budget, output int waited);
    waited = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      start = 1'b0; obs_vld = 1'b0;
      waited++;
      if ((inst == 0 && vld_a) || (inst == 1 && vld_b)) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL wait_result inst%0d: no res_vld within %0d cycles", inst, budget);
  endtask

  task automatic release_result(input logic with_start);
    @(negedge clk);
    res_rdy = 1'b1; start = with_start;
    @(negedge clk);
    res_rdy = 1'b0; start = 1'b0;
  endtask

  logic [3:0] alt[9] = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
  logic [3:0] gap[5] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
  logic [3:0] pk[5]  = '{4'h0, 4'h1, 4'h6, 4'h5, 4'hA};

  initial begin
    int w;

    // Reset state
    do_reset();
    chk_on = 1'b1;
    check_output("reset_busy", int'(busy_a), 0);
    check_output("reset_vld", int'(vld_a), 0);
    check_output("reset_count", int'(cnt_a), 0);
    check_output("reset_sat", int'(sat_a), 0);

    // Basic window 0,F,0,F,0
    send_start();
    apply_stimulus(4'h0, 1'b0);
    check_output("start_busy", int'(busy_a), 1);
    for (int i = 0; i < 5; i++) apply_stimulus(alt[i], 1'b1);
    wait_result(0, 20, w);
    check_output("basic_latency", w, 1);
    check_output("basic_count", int'(cnt_a), 16);
    check_output("basic_sat", int'(sat_a), 0);
    release_result(1'b0);
    check_output("basic_release", int'(vld_a), 0);

    // Constant inputs produce no activity
    do_reset();
    send_start();
    for (int i = 0; i < 5; i++) apply_stimulus(4'h5, 1'b1);
    wait_result(0, 20, w);
    check_output("idle_count", int'(cnt_a), 0);

    // Gapped samples with junk on invalid cycles
    do_reset();
    send_start();
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(4'hA, 1'b0);
      apply_stimulus(gap[i], 1'b1);
    end
    wait_result(0, 20, w);
    check_output("gap_latency", w, 1);
    check_output("gap_count", int'(cnt_a), 4);

    // Saturation on the narrow instance; the wide one finishes first and waits
    do_reset();
    send_start();
    for (int i = 0; i < 9; i++) apply_stimulus(alt[i], 1'b1);
    wait_result(1, 20, w);
    check_output("sat_count", int'(cnt_b), 15);
    check_output("sat_flag", int'(sat_b), 1);

    // Backpressure with a start pulse in REPORT
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = (i == 4);
      check_output("hold_vld", int'(vld_a), 1);
      check_output("hold_count", int'(cnt_a), 16);
    end
    release_result(1'b1);
    check_output("start_with_rdy_busy", int'(busy_a), 0);
    check_output("start_with_rdy_vld", int'(vld_a), 0);

    // Fresh window with toggle deltas 1,3,2,4
    send_start();
    for (int i = 0; i < 5; i++) apply_stimulus(pk[i], 1'b1);
    wait_result(0, 20, w);
    check_output("restart_count", int'(cnt_a), 10);
`ifdef ACT_PEAK_EN
    check_output("peak_value", int'(peak_a), 4);
`endif
    release_result(1'b0);

    // Reset mid-COUNT aborts with no result
    do_reset();
    send_start();
    for (int i = 0; i < 3; i++) apply_stimulus(alt[i + 1], 1'b1);
    do_reset();
    check_output("abort_busy", int'(busy_a), 0);
    check_output("abort_vld", int'(vld_a), 0);
    check_output("abort_count", int'(cnt_a), 0);
    check_output("abort_sat", int'(sat_a), 0);
    for (int i = 0; i < 5; i++) apply_stimulus(4'h3, 1'b1);
    check_output("abort_no_result", int'(vld_a), 0);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
